// File: rtl/shift_unit_seq.sv
// Multi-cycle SLL/SRL/SRA/SLA shifter for the ALU datapath.
// Advances up to STEP bits per clock; SLA raises a sticky overflow.
module shift_unit_seq #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] shamt,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             zero
);

  localparam int RW = $clog2(WIDTH + 1);
  localparam logic [RW-1:0] REM_MAX = RW'(WIDTH);
  localparam logic [RW-1:0] STEP_K = RW'(STEP);
  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] OP_SLL = 2'd0;
  localparam logic [1:0] OP_SRL = 2'd1;
  localparam logic [1:0] OP_SRA = 2'd2;
  localparam logic [1:0] OP_SLA = 2'd3;

  logic [1:0]         state;
  logic [1:0]         op_q;
  logic [RW-1:0]      rem;
  logic [RW-1:0]      rem_start;
  logic [RW-1:0]      k;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   shifted;
  logic [2*WIDTH-1:0] ext;
  logic               sign_chg;

  always_comb begin
    rem_start = shamt[RW-1:0];
    if (shamt >= W_VAL) rem_start = REM_MAX;
  end

  always_comb begin
    k = STEP_K;
    if (rem < STEP_K) k = rem;
  end

  always_comb begin
    shifted = work << k;
    unique case (1'b1)
      (op_q == OP_SRL): shifted = work >> k;
      (op_q == OP_SRA): shifted = WIDTH'($signed(work) >>> k);
      default:          shifted = work << k;
    endcase
  end

  // Zero padding below the LSB lets a full-width step see the sign flip.
  always_comb begin
    ext = {work, {WIDTH{1'b0}}};
    sign_chg = 1'b0;
    for (int i = 1; i <= STEP; i++) begin
      if (i <= int'(k) && ext[2*WIDTH-1-i] != ext[2*WIDTH-1])
        sign_chg = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= OP_SLL;
      rem   <= '0;
      work  <= '0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            work  <= a;
            op_q  <= op;
            rem   <= rem_start;
            ovf   <= 1'b0;
            zero  <= (a == '0);
            state <= (rem_start == '0) ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          work <= shifted;
          rem  <= rem - k;
          zero <= (shifted == '0);
          if (op_q == OP_SLA && sign_chg) ovf <= 1'b1;
          if (rem == k) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready  = (state == S_IDLE);
  assign done   = (state == S_DONE);
  assign result = work;

endmodule

// File: doc/shift_unit_seq.md
# shift_unit_seq

Multi-cycle, parametrised shifter for the ALU datapath. It performs logical left, logical right, arithmetic right and arithmetic left shifts of a WIDTH-bit operand, advancing up to STEP bit positions per clock. For arithmetic left shifts it raises a sticky signed-overflow flag. It uses a start/ready/done handshake so the ALU sequencer can launch one operation at a time and collect the registered result.

## Interface
- WIDTH, 16: operand/result width in bits; legal range ≥ 2.
- STEP, 1: bit positions shifted per SHIFT cycle; legal range 1..WIDTH.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- start  input  1  request strobe; accepted only when ready=1.
- op  input  2  shift mode: 00 SLL, 01 SRL, 10 SRA, 11 SLA.
- a  input  WIDTH  operand, two's complement for SRA/SLA.
- shamt  input  WIDTH  shift amount, unsigned; values ≥ WIDTH clamp to WIDTH.
- ready  output  1  block idle; a start this cycle is accepted.
- done  output  1  one-cycle pulse; result/ovf/zero valid.
- result  output  WIDTH  shifted value; holds until the next accepted start.
- ovf  output  1  SLA signed overflow; 0 for other ops.
- zero  output  1  result == 0.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE (ready=1). On start=1:
  - latch a into the working register, latch op, set rem = min(shamt, WIDTH), clear ovf.
  - next state is DONE if rem==0, else SHIFT.
- SHIFT: each cycle shift by k = min(STEP, rem), then rem -= k. Next state is DONE when rem reaches 0.
- Fill rules per mode:
  - SLL/SLA: zeros in at the LSB.
  - SRL: zeros in at the MSB.
  - SRA: copies of the current MSB in at the MSB.
- SLA overflow is sticky:
  - each SHIFT cycle, ovf |= NOT(top k+1 bits of the working register all equal), evaluated before that cycle's shift.
  - equivalent to "sign bit changed at any single-bit step".
  - for shamt ≥ WIDTH: result=0, ovf = (a != 0).
- DONE: done=1 for exactly one cycle; zero computed from the final result; next state IDLE.
- result, ovf and zero are registered and keep their values through IDLE until the next accepted start. On acceptance ovf clears; result reflects the working register.
- start while ready=0 (SHIFT or DONE): ignored, no queuing.
- op, a and shamt are sampled only on the accepting edge; later changes have no effect.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE, ready=1, done=0, result=0, ovf=0, zero=0, rem=0.
- Reset mid-operation aborts: no done pulse; ready=1 while reset is held and after release.
- Cycle numbering: start sampled high at the edge ending cycle 0. N = ceil(min(shamt,WIDTH)/STEP).
  - Cycles 1..N: SHIFT, ready=0, done=0.
  - Cycle N+1: DONE, done=1, outputs valid.
  - Cycle N+2: IDLE, ready=1.
- shamt=0: done in cycle 1, result=a, ovf=0.
- Throughput: one operation per N+2 cycles. There is no back-to-back acceptance in the DONE cycle.
- Worst case: latency ceil(WIDTH/STEP)+1 cycles.

## Test plan
- WIDTH=16, STEP=1, SLA, a=0x0003, shamt=2:
  - done high in cycle 3, result=0x000C, ovf=0, zero=0.
- SLA, a=0x4000, shamt=1:
  - result=0x8000, ovf=1.
  - then SLA a=0xC000, shamt=1 → result=0x8000, ovf=0 (sticky flag cleared on the new start).
- SRA, a=0x8000, shamt=20 (clamped to 16):
  - done in cycle 17, result=0xFFFF, ovf=0.
  - SRL a=0x8000, shamt=15 → result=0x0001.
- SLL, a=0x1234, shamt=0:
  - done in cycle 1, result=0x1234.
  - SLL a=0x0001, shamt=16 → result=0x0000, zero=1.
- Handshake and reset:
  - start re-pulsed during SHIFT with different a → ignored; result matches the first operand.
  - rst_n dropped in cycle 2 of a 10-cycle shift → no done pulse; result=0, ready=1 immediately.
- STEP=4 instance, SLA, a=0xFFFF, shamt=16:
  - 4 SHIFT cycles, done in cycle 5, result=0x0000, ovf=1, zero=1.
